// File: rtl/nmux_seq.sv
// nmux_seq: parametrised N-channel registered multiplexer with valid/ready output.
//
// A channel is chosen either by the external select (manual mode) or by an
// internal round-robin sequencer that stays DWELL transfers on each channel
// (auto mode). The chosen word is registered and presented with out_valid.
// The output register reloads only when it is empty or downstream accepts.
//
// Ports:
//   clk        clock, all logic on posedge
//   rst        asynchronous reset, active-high
//   din        NCH packed channels, channel i at din[i*WIDTH +: WIDTH]
//   mode       0 = manual select, 1 = auto round-robin
//   sel_in     manual channel select (values >= NCH clamp to NCH-1)
//   dout       registered selected data
//   sel_out    channel index that dout came from
//   out_valid  dout/sel_out valid
//   out_ready  downstream accepts when high
//   wrap       one-cycle pulse after the auto sequencer wraps NCH-1 -> 0
//   dpar       (NMUX_PARITY_EN only) XOR of dout, registered alongside it
//
// Build option: define NMUX_PARITY_EN to add the dpar output.

module nmux_seq #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned NCH   = 4,
    parameter int unsigned SELW  = 2,
    parameter int unsigned DWELL = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] din,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel_in,
    output logic [WIDTH-1:0]     dout,
    output logic [SELW-1:0]      sel_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 wrap
`ifdef NMUX_PARITY_EN
    ,
    output logic                 dpar
`endif
);

    localparam int unsigned CW = $clog2(DWELL) + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] STALL = 2'd2;

    localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);

    logic [1:0]       state;
    logic [SELW-1:0]  rr_sel;
    logic [SELW-1:0]  csel;
    logic [CW-1:0]    dwell_cnt;
    logic [CW-1:0]    dwell_base;
    logic             mode_q;
    logic             advance;
    logic             last_beat;
    logic [WIDTH-1:0] csel_data;

    // The output register takes a new word whenever it is empty or being drained.
    always_comb advance = (state != IDLE) && (!out_valid || out_ready);

    always_comb begin
        csel = '0;
        if (mode)
            csel = rr_sel;
        else if (sel_in > LAST_CH)
            csel = LAST_CH;
        else
            csel = sel_in;
    end

    always_comb begin
        csel_data = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (csel == SELW'(i))
                csel_data = din[i*WIDTH +: WIDTH];
        end
    end

    // mode_q holds the mode of the last transfer, so a mode change restarts the
    // dwell count on the first transfer made in the new mode, even if the change
    // happened during a stall.
    always_comb dwell_base = (mode != mode_q) ? '0 : dwell_cnt;
    always_comb last_beat  = (dwell_base == CW'(DWELL - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dout      <= '0;
            sel_out   <= '0;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
            rr_sel    <= '0;
            dwell_cnt <= '0;
            mode_q    <= 1'b0;
`ifdef NMUX_PARITY_EN
            dpar      <= 1'b0;
`endif
        end else begin
            wrap <= 1'b0;

            case (state)
                IDLE:       state <= RUN;
                RUN, STALL: state <= (out_valid && !out_ready) ? STALL : RUN;
                default:    state <= IDLE;
            endcase

            if (advance) begin
                dout      <= csel_data;
                sel_out   <= csel;
                out_valid <= 1'b1;
                mode_q    <= mode;
`ifdef NMUX_PARITY_EN
                dpar      <= ^csel_data;
`endif
                if (mode) begin
                    if (last_beat) begin
                        dwell_cnt <= '0;
                        rr_sel    <= (rr_sel == LAST_CH) ? '0 : rr_sel + 1'b1;
                        wrap      <= (rr_sel == LAST_CH);
                    end else begin
                        dwell_cnt <= dwell_base + 1'b1;
                    end
                end else if (mode != mode_q) begin
                    dwell_cnt <= '0;
                end
            end
        end
    end

endmodule
